arc4_key_search: RTL and testbench
==================================

ARC4_KEY_SEARCH -- requirements
Module: arc4_key_search

Interface
REQ-001 The block SHALL have parameter KEY_WIDTH, default 24: width of the key counter and key output.
REQ-002 The block SHALL have parameter KEY_FIRST, default 0: first key tried after start.
REQ-003 The block SHALL have parameter KEY_STEP, default 1: key increment, which lets parallel instances interleave; legal range 1..2^KEY_WIDTH-1.
REQ-004 The block SHALL have parameters LO_CHAR, default 8'h20, and HI_CHAR, default 8'h7E: inclusive accepted plaintext byte range.
REQ-005 The block SHALL have ports:
- CLOCK_50  in  1  clock; reset is rst_n, asynchronous, active-low; clock is CLOCK_50.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a search.
- stop  in  1  abort request, e.g. a sibling instance has found the key.
- rdy  out  1  block idle; accepts start.
- done  out  1  search finished.
- key_valid  out  1  done with a key found.
- key  out  KEY_WIDTH  current key, driven to the ARC4 core; holds the found key when key_valid=1.
- arc_en  out  1  one-cycle start pulse to the ARC4 core.
- arc_rdy  in  1  ARC4 core idle.
- pt_sel  out  1  1 = this block owns the plaintext memory port (external mux).
- pt_addr  out  8  plaintext read address.
- pt_rddata  in  8  plaintext read data, valid one cycle after pt_addr.

Function
REQ-006 States SHALL be IDLE, LAUNCH, WAIT_CORE, READ_LEN, CHECK, FOUND, FAIL.
REQ-007 rdy SHALL be 1 exactly in IDLE, FOUND and FAIL; start seen in any of these SHALL load key=KEY_FIRST, clear done/key_valid and enter LAUNCH; start in any other state SHALL be ignored.
REQ-008 In LAUNCH, arc_en SHALL pulse high for exactly one cycle, in the first cycle arc_rdy=1, then the block SHALL enter WAIT_CORE.
REQ-009 WAIT_CORE SHALL ignore arc_rdy in its first cycle, then wait for arc_rdy=1 and enter READ_LEN with pt_sel=1.
REQ-010 READ_LEN SHALL drive pt_addr=0 and capture length L from pt_rddata one cycle later.
- L=0: key accepted immediately.
- Otherwise: enter CHECK.
REQ-011 CHECK SHALL issue pt_addr 1..L on consecutive cycles and compare each returned byte one cycle later against [LO_CHAR, HI_CHAR] inclusive.
- First out-of-range byte: reject the key; remaining reads are abandoned.
- All L bytes in range: accept the key.
REQ-012 Accept SHALL enter FOUND with done=1 and key_valid=1, key held.
REQ-013 Reject SHALL compute key+KEY_STEP at KEY_WIDTH+1 bits.
- Carry out: enter FAIL with done=1, key_valid=0, key held at the last key tried.
- Otherwise: load the sum into key and return to LAUNCH.
REQ-014 pt_sel SHALL be 1 only in READ_LEN and CHECK.
REQ-015 key SHALL change only on start or in the reject step.
REQ-016 stop=1 SHALL behave per state:
- LAUNCH before arc_en, READ_LEN or CHECK: enter FAIL next cycle.
- WAIT_CORE: latch the stop and enter FAIL when arc_rdy returns to 1; no further arc_en.
- IDLE, FOUND, FAIL: no effect.
REQ-017 If stop and a final accept occur in the same cycle, accept SHALL win.
REQ-018 If start and stop occur in the same cycle while idle, start SHALL win.
REQ-019 done and key_valid SHALL remain stable until the next accepted start or reset.
REQ-020 arc_en SHALL never be asserted while arc_rdy=0.

Reset
REQ-021 rst_n low SHALL immediately force:
- state IDLE, rdy=1, done=0, key_valid=0, key=KEY_FIRST.
- arc_en=0, pt_sel=0, pt_addr=0, latched stop cleared.
REQ-022 Reset mid-operation SHALL abandon the search; the external core is reset by the same rst_n.

Verification
REQ-023 The bench SHALL cover at least these scenarios, using a behavioural ARC4 model and 1-cycle-latency memory:
- KEY_WIDTH=4, KEY_FIRST=0, KEY_STEP=1; only key 5 yields L=2 "HI" -> done=1, key_valid=1, key=5 after exactly 6 arc_en pulses.
- Same setup, no valid key -> 16 arc_en pulses, then done=1, key_valid=0, key=15.
- KEY_FIRST=1, KEY_STEP=2; only key 4 valid -> keys 1,3,..,15 tried (8 pulses), then FAIL with key=15.
- Byte boundaries: 0x20/0x7E accepted; 0x1F/0x7F rejected at that byte, with no further pt_addr increments.
- L=0 for key 0 -> FOUND after 1 pulse, key=0.
- stop asserted in WAIT_CORE -> no further arc_en; done=1, key_valid=0 the cycle after arc_rdy rises.
- rst_n low during CHECK -> all outputs at reset values asynchronously; subsequent start resumes from KEY_FIRST.

Source files
------------

// File: rtl/arc4_key_search.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arc4_key_search: steps candidate keys through an external ARC4 core and
// accepts the first key whose decrypted plaintext is entirely in range.
// Revision: 1.0
// ---------------------------------------------------------------------------
module arc4_key_search #(
    parameter int         KEY_WIDTH = 24,
    parameter int         KEY_FIRST = 0,
    parameter int         KEY_STEP  = 1,
    parameter logic [7:0] LO_CHAR   = 8'h20,
    parameter logic [7:0] HI_CHAR   = 8'h7E
) (
    input  logic                 CLOCK_50,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    output logic                 rdy,
    output logic                 done,
    output logic                 key_valid,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 arc_en,
    input  logic                 arc_rdy,
    output logic                 pt_sel,
    output logic [7:0]           pt_addr,
    input  logic [7:0]           pt_rddata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_WAIT_CORE = 3'd2;
    localparam logic [2:0] S_READ_LEN  = 3'd3;
    localparam logic [2:0] S_CHECK     = 3'd4;
    localparam logic [2:0] S_FOUND     = 3'd5;
    localparam logic [2:0] S_FAIL      = 3'd6;

    localparam logic [KEY_WIDTH-1:0] KEY_INIT = KEY_WIDTH'(KEY_FIRST);
    localparam logic [KEY_WIDTH:0]   STEP_EXT = (KEY_WIDTH+1)'(KEY_STEP);

    logic [2:0]           state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 done_q, done_d;
    logic                 key_valid_q, key_valid_d;
    logic                 stop_lat_q, stop_lat_d;
    logic                 phase_q, phase_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           addr_q, addr_d;
    logic [7:0]           cmp_q, cmp_d;

    logic                 accept;
    logic                 reject;
    logic                 byte_ok;
    logic [KEY_WIDTH:0]   key_sum;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        done_d      = done_q;
        key_valid_d = key_valid_q;
        stop_lat_d  = stop_lat_q;
        len_d       = len_q;
        addr_d      = 8'd0;
        cmp_d       = 8'd0;
        accept      = 1'b0;
        reject      = 1'b0;
        arc_en      = 1'b0;
        key_sum     = {1'b0, key_q} + STEP_EXT;
        byte_ok     = (pt_rddata >= LO_CHAR) && (pt_rddata <= HI_CHAR);

        case (state_q)
            S_IDLE, S_FOUND, S_FAIL: begin
                if (start) begin
                    state_d     = S_LAUNCH;
                    key_d       = KEY_INIT;
                    done_d      = 1'b0;
                    key_valid_d = 1'b0;
                    stop_lat_d  = 1'b0;
                end
            end
            S_LAUNCH: begin
                if (stop) begin
                    state_d = S_FAIL;
                end else if (arc_rdy) begin
                    arc_en  = 1'b1;
                    state_d = S_WAIT_CORE;
                end
            end
            S_WAIT_CORE: begin
                // The core may not have dropped arc_rdy yet in the first cycle.
                if (stop) stop_lat_d = 1'b1;
                if (phase_q && arc_rdy) begin
                    state_d = (stop_lat_q || stop) ? S_FAIL : S_READ_LEN;
                end
            end
            S_READ_LEN: begin
                if (phase_q) begin
                    len_d = pt_rddata;
                    if (pt_rddata == 8'd0) begin
                        accept = 1'b1;
                    end else if (stop) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_CHECK;
                        addr_d  = 8'd1;
                    end
                end else if (stop) begin
                    state_d = S_FAIL;
                end
            end
            S_CHECK: begin
                // cmp_q names the byte arriving now; addr_q is the read in flight.
                addr_d = addr_q;
                cmp_d  = addr_q;
                if (addr_q < len_q) addr_d = addr_q + 8'd1;
                if (cmp_q != 8'd0 && !byte_ok) begin
                    reject = 1'b1;
                end else if (cmp_q != 8'd0 && cmp_q == len_q) begin
                    accept = 1'b1;
                end else if (stop) begin
                    state_d = S_FAIL;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d     = S_FOUND;
            done_d      = 1'b1;
            key_valid_d = 1'b1;
        end else if (reject) begin
            if (stop || key_sum[KEY_WIDTH]) begin
                state_d = S_FAIL;
            end else begin
                key_d   = key_sum[KEY_WIDTH-1:0];
                state_d = S_LAUNCH;
            end
        end

        if (state_d == S_FAIL && state_q != S_FAIL) begin
            done_d      = 1'b1;
            key_valid_d = 1'b0;
        end

        phase_d = (state_d == state_q);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_q       <= KEY_INIT;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            stop_lat_q  <= 1'b0;
            phase_q     <= 1'b0;
            len_q       <= 8'd0;
            addr_q      <= 8'd0;
            cmp_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
            stop_lat_q  <= stop_lat_d;
            phase_q     <= phase_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            cmp_q       <= cmp_d;
        end
    end

    assign rdy       = (state_q == S_IDLE) || (state_q == S_FOUND) || (state_q == S_FAIL);
    assign pt_sel    = (state_q == S_READ_LEN) || (state_q == S_CHECK);
    assign pt_addr   = addr_q;
    assign key       = key_q;
    assign done      = done_q;
    assign key_valid = key_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_arc4_key_search.sv
`default_nettype none
// tb_arc4_key_search: two searchers (first 0 step 1, first 1 step 2) against a
// behavioural ARC4 core and 1-cycle plaintext memory, checked by a scoreboard.
module tb_arc4_key_search;

    localparam int NI = 2;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic       start     [NI];
    logic       stop      [NI];
    logic       rdy       [NI];
    logic       done      [NI];
    logic       key_valid [NI];
    logic [3:0] key       [NI];
    logic       arc_en    [NI];
    logic       arc_rdy   [NI];
    logic       pt_sel    [NI];
    logic [7:0] pt_addr   [NI];
    logic [7:0] pt_rddata [NI];

    always #10 CLOCK_50 = ~CLOCK_50;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        arc4_key_search #(
            .KEY_WIDTH(4),
            .KEY_FIRST(g),
            .KEY_STEP (g + 1)
        ) u_dut (
            .CLOCK_50 (CLOCK_50),
            .rst_n    (rst_n),
            .start    (start[g]),
            .stop     (stop[g]),
            .rdy      (rdy[g]),
            .done     (done[g]),
            .key_valid(key_valid[g]),
            .key      (key[g]),
            .arc_en   (arc_en[g]),
            .arc_rdy  (arc_rdy[g]),
            .pt_sel   (pt_sel[g]),
            .pt_addr  (pt_addr[g]),
            .pt_rddata(pt_rddata[g])
        );
    end

    // Plaintext the core would produce for key k, per scenario.
    int scen;
    int vkey;

    function automatic logic [7:0] pt_byte(input int s, input int vk, input logic [3:0] k,
                                           input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        case (s)
            0: begin
                if (int'(k) == vk) begin
                    if (a == 8'd0) r = 8'd2;
                    else if (a == 8'd1) r = 8'h48;
                    else if (a == 8'd2) r = 8'h49;
                end else begin
                    if (a == 8'd0) r = 8'd1;
                    else if (a == 8'd1) r = 8'h80;
                end
            end
            1: begin
                if (a == 8'd0) r = 8'd4;
                else if (a == 8'd1 || a == 8'd3) r = 8'h20;
                else if (a == 8'd2 || a == 8'd4) r = 8'h7E;
            end
            3: begin
                if (k == 4'd0) begin
                    if (a == 8'd0) r = 8'd6;
                    else if (a == 8'd1) r = 8'h20;
                    else if (a == 8'd2) r = 8'h1F;
                    else r = 8'h41;
                end else if (k == 4'd1) begin
                    if (a == 8'd0) r = 8'd6;
                    else if (a == 8'd1) r = 8'h7E;
                    else if (a == 8'd2) r = 8'h7F;
                    else r = 8'h41;
                end else if (k == 4'd2) begin
                    if (a == 8'd0) r = 8'd1;
                    else if (a == 8'd1) r = 8'h7E;
                end else begin
                    if (a == 8'd0) r = 8'd1;
                end
            end
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [3:0] core_key [NI];
    int         busy     [NI];
    int         pulses   [NI];
    int         viol;

    always @(posedge CLOCK_50 or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                busy[i]      <= 0;
                arc_rdy[i]   <= 1'b1;
                pt_rddata[i] <= 8'h00;
                core_key[i]  <= 4'd0;
            end else begin
                if (arc_en[i]) begin
                    if (!arc_rdy[i]) viol <= viol + 1;
                    core_key[i] <= key[i];
                    busy[i]     <= 3;
                    arc_rdy[i]  <= 1'b0;
                    pulses[i]   <= pulses[i] + 1;
                end else if (busy[i] == 1) begin
                    busy[i]    <= 0;
                    arc_rdy[i] <= 1'b1;
                end else if (busy[i] > 1) begin
                    busy[i] <= busy[i] - 1;
                end
                pt_rddata[i] <= pt_byte(scen, vkey, core_key[i], pt_addr[i]);
            end
        end
    end

    typedef struct {
        int   inst;
        logic kv;
        int   k;
        int   pulses;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    logic done_prev [NI];

    always @(negedge CLOCK_50) begin
        for (int i = 0; i < NI; i++) begin
            if (rst_n && done[i] && !done_prev[i]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected done on instance", i, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done instance", i, mon_e.inst);
                    chk("key_valid", int'(key_valid[i]), int'(mon_e.kv));
                    chk("key", int'(key[i]), mon_e.k);
                    chk("arc_en pulses", pulses[i], mon_e.pulses);
                    chk("rdy at done", int'(rdy[i]), 1);
                    chk("arc_en while core busy", viol, 0);
                end
            end
            done_prev[i] <= done[i];
        end
    end

    int maxa [16];

    task automatic pulse_start(input int i);
        @(negedge CLOCK_50);
        start[i] = 1'b1;
        @(negedge CLOCK_50);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge CLOCK_50);
            if (pt_sel[i] && int'(pt_addr[i]) > maxa[key[i]]) maxa[key[i]] = int'(pt_addr[i]);
            if (done[i]) break;
        end
        if (n == 2000) chk("search timeout", 0, 1);
    endtask

    task automatic search(input int i, input int s, input int vk, input logic kv,
                          input int k, input int np);
        exp_t e;
        scen = s;
        vkey = vk;
        for (int j = 0; j < 16; j++) maxa[j] = 0;
        e.inst   = i;
        e.kv     = kv;
        e.k      = k;
        e.pulses = pulses[i] + np;
        exp_q.push_back(e);
        pulse_start(i);
        wait_done(i);
        repeat (2) @(negedge CLOCK_50);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;
        int   base;
        rst_n = 1'b0;
        scen  = 0;
        vkey  = 16;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            stop[i]  = 1'b0;
        end
        repeat (3) @(negedge CLOCK_50);
        for (int i = 0; i < NI; i++) begin
            chk("reset rdy", int'(rdy[i]), 1);
            chk("reset done", int'(done[i]), 0);
            chk("reset key_valid", int'(key_valid[i]), 0);
            chk("reset key", int'(key[i]), i);
            chk("reset arc_en", int'(arc_en[i]), 0);
            chk("reset pt_sel", int'(pt_sel[i]), 0);
            chk("reset pt_addr", int'(pt_addr[i]), 0);
        end
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        @(negedge CLOCK_50);

        search(0, 0, 5, 1'b1, 5, 6);
        search(0, 0, 16, 1'b0, 15, 16);
        search(1, 0, 4, 1'b0, 15, 8);
        search(0, 1, 16, 1'b1, 0, 1);
        search(0, 2, 16, 1'b1, 0, 1);
        search(0, 3, 16, 1'b1, 2, 3);
        chk("reads after 0x1F reject", maxa[0], 3);
        chk("reads after 0x7F reject", maxa[1], 3);

        // Stop while waiting for the core.
        scen = 0;
        vkey = 16;
        base = pulses[0];
        e.inst = 0; e.kv = 1'b0; e.k = 0; e.pulses = base + 1;
        exp_q.push_back(e);
        pulse_start(0);
        for (n = 0; n < 50 && !arc_en[0]; n++) @(negedge CLOCK_50);
        chk("arc_en seen before stop", int'(arc_en[0]), 1);
        @(negedge CLOCK_50);
        stop[0] = 1'b1;
        @(negedge CLOCK_50);
        stop[0] = 1'b0;
        for (n = 0; n < 50 && !arc_rdy[0]; n++) @(negedge CLOCK_50);
        chk("done while core busy", int'(done[0]), 0);
        @(negedge CLOCK_50);
        chk("done after core idle", int'(done[0]), 1);
        chk("key_valid after stop", int'(key_valid[0]), 0);
        repeat (10) @(negedge CLOCK_50);
        chk("no arc_en after stop", pulses[0], base + 1);

        // Asynchronous reset in the middle of the byte check.
        scen = 0;
        vkey = 5;
        pulse_start(0);
        for (n = 0; n < 200 && !(pt_sel[0] && pt_addr[0] != 8'd0); n++) @(negedge CLOCK_50);
        chk("reached byte check", int'(pt_sel[0] && pt_addr[0] != 8'd0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset rdy", int'(rdy[0]), 1);
        chk("async reset done", int'(done[0]), 0);
        chk("async reset key_valid", int'(key_valid[0]), 0);
        chk("async reset key", int'(key[0]), 0);
        chk("async reset arc_en", int'(arc_en[0]), 0);
        chk("async reset pt_sel", int'(pt_sel[0]), 0);
        chk("async reset pt_addr", int'(pt_addr[0]), 0);
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        @(negedge CLOCK_50);
        search(0, 0, 5, 1'b1, 5, 6);

        repeat (5) @(negedge CLOCK_50);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
